// File: rtl/dmux_stream_collector.sv
// dmux_stream_collector
//   Valid/ready front-end and per-destination collector around an external
//   pipelined demux. Accepted beats are forwarded to the demux together with
//   their select. A matching tag pipeline follows each beat through the demux
//   latency. When a beat leaves the demux, its slice is captured into the
//   FIFO of its destination. Each FIFO drains through its own valid/ready
//   channel. Per-destination credits count beats in flight plus beats stored,
//   so no FIFO can overflow.
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   in_valid    upstream beat valid
//   in_ready    upstream beat accepted
//   in_sel      destination index (values >= OUTPUT_COUNT are dropped)
//   in_data     upstream beat payload
//   dmux_sel    select to the demux (mirrors in_sel)
//   dmux_in     data to the demux (in_data on accept, else 0)
//   dmux_out    demux output slices, slice i belongs to destination i
//   out_valid   per-destination head valid
//   out_ready   per-destination consumer ready
//   out_data    per-destination head data
//   err_drop    one-cycle pulse after an out-of-range beat is consumed
module dmux_stream_collector #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned OUTPUT_COUNT = 2,
  parameter int unsigned DMUX_LATENCY = 0,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [$clog2(OUTPUT_COUNT):0]     in_sel,
  input  logic [WIDTH-1:0]                  in_data,
  output logic [$clog2(OUTPUT_COUNT):0]     dmux_sel,
  output logic [WIDTH-1:0]                  dmux_in,
  input  logic [WIDTH*OUTPUT_COUNT-1:0]     dmux_out,
  output logic [OUTPUT_COUNT-1:0]           out_valid,
  input  logic [OUTPUT_COUNT-1:0]           out_ready,
  output logic [WIDTH*OUTPUT_COUNT-1:0]     out_data,
  output logic                              err_drop
);

  localparam int unsigned SELW = $clog2(OUTPUT_COUNT) + 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    r_cnt  [OUTPUT_COUNT];
  logic [CW-1:0]    r_occ  [OUTPUT_COUNT];
  logic [PW-1:0]    r_wptr [OUTPUT_COUNT];
  logic [PW-1:0]    r_rptr [OUTPUT_COUNT];
  logic [WIDTH-1:0] r_mem  [OUTPUT_COUNT][DEPTH];
  logic             r_err;

  logic                    w_sel_ok;
  logic                    w_cred_ok;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_tag_v;
  logic [SELW-1:0]         w_tag_s;
  logic [OUTPUT_COUNT-1:0] w_acc_i;
  logic [OUTPUT_COUNT-1:0] w_wr_i;
  logic [OUTPUT_COUNT-1:0] w_pop_i;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Per-destination decode is done by comparison loops so that an
  // out-of-range in_sel never indexes past the credit array.
  always_comb begin
    w_sel_ok  = (in_sel < SELW'(OUTPUT_COUNT));
    w_cred_ok = 1'b0;
    for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
      if (in_sel == SELW'(i)) w_cred_ok = (r_cnt[i] < CW'(DEPTH));
    end
    in_ready = !rst && (w_sel_ok ? w_cred_ok : 1'b1);
    w_accept = in_valid && in_ready && w_sel_ok;
    w_drop   = in_valid && in_ready && !w_sel_ok;
    dmux_sel = in_sel;
    dmux_in  = w_accept ? in_data : '0;
    err_drop = r_err;

    w_acc_i   = '0;
    w_wr_i    = '0;
    w_pop_i   = '0;
    out_valid = '0;
    out_data  = '0;
    for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
      w_acc_i[i]   = w_accept && (in_sel == SELW'(i));
      w_wr_i[i]    = w_tag_v && (w_tag_s == SELW'(i));
      out_valid[i] = (r_occ[i] != '0);
      w_pop_i[i]   = out_valid[i] && out_ready[i];
      out_data[i*WIDTH +: WIDTH] = r_mem[i][r_rptr[i]];
    end
  end

  // Tag pipeline: the tag leaves on the same cycle as its beat leaves the demux.
  if (DMUX_LATENCY == 0) begin : g_tag_comb
    always_comb begin
      w_tag_v = w_accept;
      w_tag_s = in_sel;
    end
  end else begin : g_tag_pipe
    logic            r_tv [DMUX_LATENCY];
    logic [SELW-1:0] r_ts [DMUX_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < DMUX_LATENCY; k++) begin
          r_tv[k] <= 1'b0;
          r_ts[k] <= '0;
        end
      end else begin
        r_tv[0] <= w_accept;
        r_ts[0] <= in_sel;
        for (int unsigned k = 1; k < DMUX_LATENCY; k++) begin
          r_tv[k] <= r_tv[k-1];
          r_ts[k] <= r_ts[k-1];
        end
      end
    end

    always_comb begin
      w_tag_v = r_tv[DMUX_LATENCY-1];
      w_tag_s = r_ts[DMUX_LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
        r_cnt[i]  <= '0;
        r_occ[i]  <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      r_err <= w_drop;
      for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
        if (w_wr_i[i])  r_wptr[i] <= f_inc(r_wptr[i]);
        if (w_pop_i[i]) r_rptr[i] <= f_inc(r_rptr[i]);
        r_occ[i] <= r_occ[i] + CW'(w_wr_i[i])  - CW'(w_pop_i[i]);
        r_cnt[i] <= r_cnt[i] + CW'(w_acc_i[i]) - CW'(w_pop_i[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
      if (w_wr_i[i]) r_mem[i][r_wptr[i]] <= dmux_out[i*WIDTH +: WIDTH];
    end
  end

  for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : g_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_wr_i[g] && (r_occ[g] == CW'(DEPTH))));
  end

endmodule

// File: tb/tb_dmux_stream_collector.sv
// Randomized bench for dmux_stream_collector with a queue-based reference
// model and a behavioural pipelined demux (not reset, so stale beats keep
// flowing out of it after a reset).
module tb_dmux_stream_collector;

  localparam int W = 8;
  localparam int N = 2;
  localparam int L = 2;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [1:0]     dmux_sel;
  logic [W-1:0]   dmux_in;
  logic [W*N-1:0] dmux_out;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [W*N-1:0] out_data;
  logic           err_drop;

  always #5 clk = ~clk;

  dmux_stream_collector #(
    .WIDTH(W), .OUTPUT_COUNT(N), .DMUX_LATENCY(L), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .dmux_sel(dmux_sel), .dmux_in(dmux_in), .dmux_out(dmux_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_drop(err_drop)
  );

  // Behavioural demux: L register stages, selected slice carries data.
  logic [1:0]   p_sel [L];
  logic [W-1:0] p_dat [L];
  always @(posedge clk) begin
    p_sel[0] <= dmux_sel;
    p_dat[0] <= dmux_in;
    for (int k = 1; k < L; k++) begin
      p_sel[k] <= p_sel[k-1];
      p_dat[k] <= p_dat[k-1];
    end
  end
  always_comb begin
    dmux_out = '0;
    if (p_sel[L-1] < 2'(N)) dmux_out[p_sel[L-1]*W +: W] = p_dat[L-1];
  end

  // Reference model: per-channel queue of (data, first visible cycle).
  logic [W-1:0] qd [N][$];
  int unsigned  qv [N][$];
  int unsigned  cyc;
  logic         m_err, m_acc, m_drop, m_ready;
  logic [N-1:0] m_ov;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        qd[i].delete();
        qv[i].delete();
      end
      m_err = 1'b0;
    end
    for (int i = 0; i < N; i++) m_ov[i] = (qd[i].size() > 0) && (qv[i][0] <= cyc);
    m_ready = rst ? 1'b0 : (in_sel >= 2'(N)) ? 1'b1 : (qd[int'(in_sel)].size() < D);
    m_acc   = in_valid && m_ready && (in_sel < 2'(N));
    m_drop  = in_valid && m_ready && (in_sel >= 2'(N));
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_ov);
    check("err_drop", err_drop, m_err);
    check("dmux_sel", dmux_sel, in_sel);
    check("dmux_in", dmux_in, m_acc ? in_data : '0);
    for (int i = 0; i < N; i++)
      if (m_ov[i]) check($sformatf("out_data%0d", i), out_data[i*W +: W], qd[i][0]);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (m_ov[i] && out_ready[i]) begin
        void'(qd[i].pop_front());
        void'(qv[i].pop_front());
      end
    end
    if (m_acc) begin
      qd[int'(in_sel)].push_back(in_data);
      qv[int'(in_sel)].push_back(cyc + L + 1);
    end
    m_err = m_drop;
    cyc++;
    #1;
  endtask

  task automatic idle(input logic [N-1:0] ordy, input int n);
    in_valid  = 1'b0;
    out_ready = ordy;
    repeat (n) run_cycle();
  endtask

  // Hold a beat until the model says it is taken; a bound that expires counts as a failure.
  task automatic send(input logic [1:0] s, input logic [W-1:0] d, input logic [N-1:0] ordy, input int maxc);
    int   k;
    logic done;
    in_valid  = 1'b1;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    done      = 1'b0;
    k         = 0;
    while (!done && k < maxc) begin
      run_cycle();
      done = m_acc || m_drop;
      k++;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    cyc = 0; m_err = 1'b0;
    #1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
    idle(2'b00, 2);

    // Single beat, latency observed by the model each cycle.
    send(2'd1, 8'hA5, 2'b00, 4);
    idle(2'b00, 4);
    idle(2'b11, 2);

    // Stalled channel 0 fills after two beats; third waits, then issues in order.
    send(2'd0, 8'h01, 2'b00, 4);
    send(2'd0, 8'h02, 2'b00, 4);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h03; out_ready = 2'b00;
    repeat (4) run_cycle();
    send(2'd0, 8'h03, 2'b01, 10);
    idle(2'b11, 8);

    // Back-to-back alternating destinations with both consumers ready.
    send(2'd0, 8'h10, 2'b11, 1);
    send(2'd1, 8'h11, 2'b11, 1);
    send(2'd0, 8'h12, 2'b11, 1);
    send(2'd1, 8'h13, 2'b11, 1);
    idle(2'b11, 6);

    // Same-cycle accept and pop on channel 0 at one credit used.
    send(2'd0, 8'h21, 2'b00, 4);
    idle(2'b00, 4);
    send(2'd0, 8'h22, 2'b01, 4);
    send(2'd0, 8'h23, 2'b01, 4);
    idle(2'b11, 6);

    // Out-of-range selects are consumed and flagged once each.
    send(2'd2, 8'h99, 2'b11, 2);
    idle(2'b11, 3);
    send(2'd3, 8'h98, 2'b11, 2);
    send(2'd1, 8'h31, 2'b11, 2);
    idle(2'b11, 5);

    // Reset with stored and in-flight beats; nothing may surface afterwards.
    send(2'd0, 8'h44, 2'b00, 4);
    idle(2'b00, 3);
    send(2'd1, 8'h55, 2'b00, 4);
    send(2'd0, 8'h77, 2'b00, 4);
    rst = 1'b1;
    #1;
    check("rst_async_ov", out_valid, 2'b00);
    check("rst_async_rdy", in_ready, 1'b0);
    run_cycle();
    rst = 1'b0;
    idle(2'b00, L + 2);
    idle(2'b11, 2);

    // Randomized traffic with varying consumer stalls and occasional resets.
    begin
      logic [N-1:0] stall_mask;
      stall_mask = '0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 50 == 0) stall_mask = N'($urandom);
        rst      = ($urandom_range(0, 499) == 0);
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        out_ready = N'($urandom) | ~stall_mask;
        run_cycle();
      end
      rst = 1'b0;
    end
    idle(2'b11, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
